// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in, parallel-out receiver.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    // Bit-counter width for a given word width; holds 0..WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_deserializer_word_hold.sv
// Single-entry valid/ready holding register for assembled words, with a
// sticky overrun flag when a completed word arrives while the slot is full.
import sipo_pkg::*;

module word_hold_reg #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_word,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_word;
    logic             r_valid;
    logic             r_overrun;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_load) begin
            // A word consumed this cycle frees the slot for the new one.
            if (!r_valid || i_ready) begin
                r_word  <= i_word;
                r_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_word    = r_word;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: frames WIDTH bits starting at a sync
// strobe and hands each completed word to a valid/ready holding register.
import sipo_pkg::*;

module sipo_deserializer #(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si_en,
    input  logic             si,
    input  logic             sync,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int              CNT_W_L = cnt_width(WIDTH);
    localparam logic [CNT_W_L-1:0] LAST = CNT_W_L'(WIDTH - 1);
    localparam logic [CNT_W_L-1:0] ONE  = CNT_W_L'(1);

    sipo_state_t       r_state;
    logic [WIDTH-1:0]  r_shift;
    logic [CNT_W_L-1:0] r_cnt;
    logic              r_busy;

    logic [WIDTH-1:0]  w_first;
    logic [WIDTH-1:0]  w_next;
    logic              w_done;

    // First bit sits at the end that will migrate to its final position.
    assign w_first = MSB_FIRST ? {{(WIDTH-1){1'b0}}, si} : {si, {(WIDTH-1){1'b0}}};
    assign w_next  = MSB_FIRST ? {r_shift[WIDTH-2:0], si} : {si, r_shift[WIDTH-1:1]};
    assign w_done  = (r_state == SHIFT) && si_en && !sync && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (si_en && sync) begin
                        r_shift <= w_first;
                        r_cnt   <= ONE;
                        r_state <= SHIFT;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (si_en) begin
                        if (sync) begin
                            r_shift <= w_first;
                            r_cnt   <= ONE;
                        end else if (r_cnt == LAST) begin
                            r_shift <= w_next;
                            r_cnt   <= '0;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_shift <= w_next;
                            r_cnt   <= r_cnt + ONE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;

    word_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_done),
        .i_word   (w_next),
        .i_ready  (po_ready),
        .o_word   (po),
        .o_valid  (po_valid),
        .o_overrun(overrun)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: MSB-first and LSB-first instances share one stimulus stream.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       si_en = 1'b0;
    logic       si = 1'b0;
    logic       sync = 1'b0;
    logic       po_ready = 1'b0;
    logic [3:0] po_m, po_l;
    logic       vld_m, vld_l, busy_m, busy_l, ovr_m, ovr_l;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .si_en(si_en), .si(si), .sync(sync),
        .po(po_m), .po_valid(vld_m), .po_ready(po_ready),
        .busy(busy_m), .overrun(ovr_m)
    );

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .si_en(si_en), .si(si), .sync(sync),
        .po(po_l), .po_valid(vld_l), .po_ready(po_ready),
        .busy(busy_l), .overrun(ovr_l)
    );

    task automatic send_bit(input logic b, input logic s);
        @(negedge clk);
        si_en = 1'b1;
        si    = b;
        sync  = s;
        @(posedge clk);
        #1;
        si_en = 1'b0;
        sync  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_cycle();
        checks++; if (po_m !== 4'b0000) begin errors++; $display("FAIL reset_po: got %b want 0000", po_m); end
        checks++; if (vld_m !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", vld_m); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_m); end
        checks++; if (ovr_m !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", ovr_m); end
        checks++; if ({po_l, vld_l, busy_l, ovr_l} !== 7'b0) begin errors++; $display("FAIL reset_lsb_inst: got %b want 0", {po_l, vld_l, busy_l, ovr_l}); end
    endtask

    task automatic test_back_to_back();
        po_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy_m); end
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        checks++; if (vld_m !== 1'b0) begin errors++; $display("FAIL b2b_early_valid: got %b want 0", vld_m); end
        send_bit(1'b1, 1'b0);
        checks++; if (vld_m !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", vld_m); end
        checks++; if (po_m !== 4'b1101) begin errors++; $display("FAIL b2b_po_msb: got %b want 1101", po_m); end
        checks++; if (po_l !== 4'b1011) begin errors++; $display("FAIL b2b_po_lsb: got %b want 1011", po_l); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", busy_m); end
        idle_cycle();
        checks++; if (vld_m !== 1'b0) begin errors++; $display("FAIL b2b_valid_pulse: got %b want 0", vld_m); end
        checks++; if (po_m !== 4'b1101) begin errors++; $display("FAIL b2b_po_kept: got %b want 1101", po_m); end
    endtask

    task automatic test_gapped();
        send_bit(1'b1, 1'b0);
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL stray_busy: got %b want 0", busy_m); end
        checks++; if (vld_m !== 1'b0) begin errors++; $display("FAIL stray_valid: got %b want 0", vld_m); end
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            repeat (2) begin
                idle_cycle();
                checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL gap_busy: got %b want 1 (bit %0d)", busy_m, i); end
            end
            send_bit(1'b0, 1'b0);
        end
        checks++; if (po_m !== 4'b1000) begin errors++; $display("FAIL gap_po_msb: got %b want 1000", po_m); end
        checks++; if (po_l !== 4'b0001) begin errors++; $display("FAIL gap_po_lsb: got %b want 0001", po_l); end
        checks++; if (vld_m !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b want 1", vld_m); end
        idle_cycle();
    endtask

    task automatic test_backpressure();
        po_ready = 1'b0;
        send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        checks++; if (po_m !== 4'b1101 || vld_m !== 1'b1) begin errors++; $display("FAIL bp_first: got po=%b v=%b want 1101/1", po_m, vld_m); end
        checks++; if (ovr_m !== 1'b0) begin errors++; $display("FAIL bp_no_overrun: got %b want 0", ovr_m); end
        send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        checks++; if (ovr_m !== 1'b0) begin errors++; $display("FAIL bp_overrun_early: got %b want 0", ovr_m); end
        send_bit(1'b0, 1'b0);
        checks++; if (ovr_m !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b want 1", ovr_m); end
        checks++; if (po_m !== 4'b1101 || vld_m !== 1'b1) begin errors++; $display("FAIL bp_hold: got po=%b v=%b want 1101/1", po_m, vld_m); end
        checks++; if (po_l !== 4'b1011 || ovr_l !== 1'b1) begin errors++; $display("FAIL bp_lsb: got po=%b o=%b want 1011/1", po_l, ovr_l); end
        @(negedge clk);
        po_ready = 1'b1;
        idle_cycle();
        @(negedge clk);
        po_ready = 1'b0;
        checks++; if (vld_m !== 1'b0) begin errors++; $display("FAIL bp_consume: got %b want 0", vld_m); end
        checks++; if (po_m !== 4'b1101) begin errors++; $display("FAIL bp_po_after: got %b want 1101", po_m); end
        checks++; if (ovr_m !== 1'b1) begin errors++; $display("FAIL bp_sticky: got %b want 1", ovr_m); end
    endtask

    task automatic test_resync();
        po_ready = 1'b1;
        send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0);
        checks++; if (vld_m !== 1'b0) begin errors++; $display("FAIL resync_no_word: got %b want 0", vld_m); end
        send_bit(1'b1, 1'b0);
        checks++; if (vld_m !== 1'b0) begin errors++; $display("FAIL resync_no_word2: got %b want 0", vld_m); end
        send_bit(1'b0, 1'b0);
        checks++; if (po_m !== 4'b1010 || vld_m !== 1'b1) begin errors++; $display("FAIL resync_po: got po=%b v=%b want 1010/1", po_m, vld_m); end
        checks++; if (po_l !== 4'b0101) begin errors++; $display("FAIL resync_po_lsb: got %b want 0101", po_l); end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        po_ready = 1'b0;
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();
        @(negedge clk);
        rst = 1'b1;
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy_m); end
        checks++; if (vld_m !== 1'b0 || po_m !== 4'b0000) begin errors++; $display("FAIL mid_out: got po=%b v=%b want 0000/0", po_m, vld_m); end
        checks++; if (ovr_m !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %b want 0", ovr_m); end
        send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        checks++; if (vld_m !== 1'b0) begin errors++; $display("FAIL mid_early: got %b want 0", vld_m); end
        send_bit(1'b1, 1'b0);
        checks++; if (po_m !== 4'b0011 || vld_m !== 1'b1) begin errors++; $display("FAIL mid_po: got po=%b v=%b want 0011/1", po_m, vld_m); end
        checks++; if (po_l !== 4'b1100) begin errors++; $display("FAIL mid_po_lsb: got %b want 1100", po_l); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped();
        test_backpressure();
        test_resync();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in, parallel-out receiver. Collects WIDTH serial bits into one parallel word and presents it on a valid/ready output port. It is the receiving end of the serial link whose words are shifted out by the team's parallel-in shift registers, and it delivers words into PIPO-style parallel stages downstream.

Parameters:
WIDTH, 4, word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 1, bit order on the link. 1: first serial bit lands in po[WIDTH-1]. 0: first bit lands in po[0].

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous reset, active-low; sampled on the clk rising edge.
si_en  input  1  bit strobe; si is valid this cycle.
si  input  1  serial data bit.
sync  input  1  frame start; qualified by si_en; marks the current bit as bit 0 of a word.
po  output  WIDTH  assembled parallel word.
po_valid  output  1  po holds an unconsumed word.
po_ready  input  1  consumer accepts po this cycle.
busy  output  1  frame reception in progress.
overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; shift register=0; bit count=0.
  - po=0; po_valid=0; busy=0; overrun=0.
  - Reset mid-frame discards the partial word. Reset with po_valid=1 discards the pending word.
- FSM states: IDLE, SHIFT. busy = (state==SHIFT), registered.
- IDLE:
  - si_en & sync: capture si as bit 0, count=1, go to SHIFT.
  - si_en without sync: bit is ignored.
- SHIFT:
  - si_en=0: hold state, count and shift register.
  - si_en & sync: resync. Discard the partial word, capture si as the new bit 0, count=1, stay in SHIFT.
  - si_en & !sync with count<WIDTH-1: shift the bit in, count++.
  - si_en & !sync with count==WIDTH-1: this is the last bit. The completed word goes to the output stage and state returns to IDLE.
- Bit order:
  - MSB_FIRST=1: shift left, inserting at the LSB. First bit ends in po[WIDTH-1].
  - MSB_FIRST=0: shift right, inserting at the MSB. First bit ends in po[0].
- Output stage (single-entry holding register):
  - A word completes at edge N. If po_valid==0, or po_valid & po_ready in that cycle, po loads the word and po_valid=1 after edge N. Latency from the last si_en edge is one clock.
  - Completion coinciding with acceptance: the old word is consumed and the new word is loaded in the same edge; po_valid stays 1.
  - Completion while po_valid=1 and po_ready=0: the new word is dropped, po is unchanged, and overrun is set to 1.
  - po_valid & po_ready with no completion: po_valid=0 at the next edge; po keeps its last value.
  - po is stable while po_valid=1 and po_ready=0.
- overrun clears only on reset.
- The bit counter is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.

Decomposition:
- Package sipo_pkg: state enum {IDLE, SHIFT}; localparam CNT_W = $clog2(WIDTH).
- One sub-module: word_hold_reg, the WIDTH-bit valid/ready holding register with overrun detect. It is instantiated once. The FSM, counter and shift register stay in the top module.

Test Plan:
All scenarios use WIDTH=4, MSB_FIRST=1 unless stated.
1. Reset: rst=0 for 2 cycles, then rst=1 -> po=4'b0000, po_valid=0, busy=0, overrun=0.
2. Back-to-back frame 1,1,0,1 (sync with the first bit), po_ready=1 -> po=4'b1101, po_valid high exactly one cycle, starting one clock after the 4th bit. Same stimulus with MSB_FIRST=0 -> po=4'b1011.
3. Gapped frame 1,0,0,0 with 2 idle cycles between strobes -> busy high throughout; po=4'b1000 after the last bit. A stray si_en without sync while in IDLE -> no state change.
4. Backpressure: po_ready=0; send 1101, then 0110.
   - po stays 4'b1101 with po_valid=1.
   - overrun=1 after the 2nd frame's last bit.
   - Raise po_ready for 1 cycle -> po_valid=0, po stays 4'b1101.
5. Resync: send 1,1, then sync with bits 1,0,1,0 -> po=4'b1010; no word is produced from the abandoned bits.
6. Reset mid-operation: after 2 bits pulse rst=0 for 1 cycle -> busy=0, po_valid=0, overrun=0. Then frame 0,0,1,1 -> po=4'b0011.
